// File: rtl/ctx_pkg.sv
// Shared types and default sizing for the context switch unit.
package ctx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SAVE    = 2'd2,
    RESTORE = 2'd3
  } ctx_state_e;

  localparam int DEF_NUM_PROC   = 4;
  localparam int DEF_PC_W       = 32;
  localparam int DEF_QNT_W      = 8;
  localparam int DEF_OFS_W      = 12;
  localparam int DEF_OFS_STRIDE = 1024;

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin slot picker: first set mask bit after start, wrapping, start itself last.
module rr_next_sel
  import ctx_pkg::*;
#(
  parameter int NUM_PROC = DEF_NUM_PROC,
  parameter int ID_W     = $clog2(NUM_PROC)
) (
  input  logic [NUM_PROC-1:0] mask,
  input  logic [ID_W-1:0]     start,
  output logic                found,
  output logic [ID_W-1:0]     id
);

  localparam logic [ID_W:0] NP_EXT = (ID_W+1)'(NUM_PROC);

  logic [ID_W:0] cand;

  // Scan farthest candidate first so the nearest valid slot wins.
  always_comb begin
    found = 1'b0;
    id    = {ID_W{1'b0}};
    cand  = {(ID_W+1){1'b0}};
    for (int i = NUM_PROC; i >= 1; i--) begin
      cand = {1'b0, start} + (ID_W+1)'(i);
      if (cand >= NP_EXT) begin
        cand = cand - NP_EXT;
      end else begin
        cand = cand;
      end
      if (mask[cand[ID_W-1:0]]) begin
        found = 1'b1;
        id    = cand[ID_W-1:0];
      end else begin
        found = found;
        id    = id;
      end
    end
  end

endmodule

// File: rtl/context_switch_unit.sv
// Time-sliced process dispatcher: saves the running PC, picks the next
// valid slot round-robin and drives the processor PC reload.
module context_switch_unit
  import ctx_pkg::*;
#(
  parameter int NUM_PROC   = DEF_NUM_PROC,
  parameter int PC_W       = DEF_PC_W,
  parameter int QNT_W      = DEF_QNT_W,
  parameter int OFS_W      = DEF_OFS_W,
  parameter int OFS_STRIDE = DEF_OFS_STRIDE,
  localparam int ID_W      = $clog2(NUM_PROC)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                step,
  input  logic [PC_W-1:0]     next_pc,
  input  logic                proc_exit,
  input  logic [QNT_W-1:0]    quantum,
  input  logic                load_valid,
  input  logic [ID_W-1:0]     load_id,
  input  logic [PC_W-1:0]     load_pc,
  output logic                pc_load,
  output logic [PC_W-1:0]     restore_pc,
  output logic                stall,
  output logic [ID_W-1:0]     cur_proc,
  output logic [OFS_W-1:0]    proc_offset,
  output logic                in_program,
  output logic [NUM_PROC-1:0] active_mask,
  output logic                load_err
);

  localparam logic [ID_W:0]    NP_EXT   = (ID_W+1)'(NUM_PROC);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_PROC - 1);
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'((NUM_PROC - 1) * OFS_STRIDE);

  ctx_state_e state;
  ctx_state_e state_next;

  logic [PC_W-1:0]     slot_pc [NUM_PROC];
  logic [QNT_W-1:0]    slice_cnt;
  logic                slice_en;
  logic [PC_W-1:0]     save_pc;
  logic                save_exit;

  logic                trigger;
  logic                load_hit_cur;
  logic                load_ok;
  logic                dispatch;
  logic                sel_found;
  logic [ID_W-1:0]     sel_id;
  logic [NUM_PROC-1:0] sel_mask;
  logic [NUM_PROC-1:0] mask_next;
  logic [PC_W-1:0]     dispatch_pc;

  // Switch trigger, load arbitration and the mask seen by selection.
  always_comb begin
    trigger      = (state == RUN) && step &&
                   (proc_exit || (slice_en && (slice_cnt == QNT_W'(1))));
    load_hit_cur = load_valid && (load_id == cur_proc) && (state != IDLE);
    load_ok      = load_valid && !load_hit_cur && ({1'b0, load_id} < NP_EXT);
    sel_mask     = active_mask;
    if ((state == SAVE) && save_exit) begin
      sel_mask[cur_proc] = 1'b0;
    end else begin
      sel_mask = active_mask;
    end
    // A same-cycle load lands in the mask but stays out of this selection.
    mask_next = sel_mask;
    if (load_ok) begin
      mask_next[load_id] = 1'b1;
    end else begin
      mask_next = sel_mask;
    end
  end

  rr_next_sel #(
    .NUM_PROC (NUM_PROC),
    .ID_W     (ID_W)
  ) u_sel (
    .mask  (sel_mask),
    .start (cur_proc),
    .found (sel_found),
    .id    (sel_id)
  );

  // PC handed out on dispatch, forwarding table writes landing on the same edge.
  always_comb begin
    if (load_ok && (load_id == sel_id)) begin
      dispatch_pc = load_pc;
    end else if ((state == SAVE) && !save_exit && (sel_id == cur_proc)) begin
      dispatch_pc = save_pc;
    end else begin
      dispatch_pc = slot_pc[sel_id];
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    dispatch   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_next = RESTORE;
          dispatch   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (trigger) begin
          state_next = SAVE;
        end else begin
          state_next = RUN;
        end
      end
      SAVE: begin
        if (sel_found) begin
          state_next = RESTORE;
          dispatch   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RESTORE: begin
        state_next = RUN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Control registers and registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      active_mask <= {NUM_PROC{1'b0}};
      cur_proc    <= LAST_ID;
      proc_offset <= LAST_OFS;
      slice_cnt   <= {QNT_W{1'b0}};
      slice_en    <= 1'b0;
      save_pc     <= {PC_W{1'b0}};
      save_exit   <= 1'b0;
      pc_load     <= 1'b0;
      restore_pc  <= {PC_W{1'b0}};
      stall       <= 1'b1;
      in_program  <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      active_mask <= mask_next;
      pc_load     <= dispatch;
      stall       <= (state_next != RUN);
      in_program  <= (state_next == RUN);
      load_err    <= load_valid && !load_ok;
      if (dispatch) begin
        cur_proc    <= sel_id;
        proc_offset <= OFS_W'(int'(sel_id) * OFS_STRIDE);
        restore_pc  <= dispatch_pc;
      end
      // The slice length is latched once per dispatch; quantum edits wait a slice.
      if (state == RESTORE) begin
        slice_cnt <= quantum;
        slice_en  <= (quantum != {QNT_W{1'b0}});
      end else if ((state == RUN) && step && slice_en) begin
        slice_cnt <= slice_cnt - QNT_W'(1);
      end
      if (trigger) begin
        save_pc   <= next_pc;
        save_exit <= proc_exit;
      end
    end
  end

  // Slot PC table; contents are only meaningful for slots whose mask bit is set.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_PROC; i++) begin
      if (load_ok && (int'(load_id) == i)) begin
        slot_pc[i] <= load_pc;
      end else if ((state == SAVE) && !save_exit && (int'(cur_proc) == i)) begin
        slot_pc[i] <= save_pc;
      end
    end
  end

endmodule

// File: doc/context_switch_unit.md
CONTEXT_SWITCH_UNIT -- requirements
Module: context_switch_unit

Interface
REQ-001 The block SHALL have parameter NUM_PROC, default 4: number of process slots, 2..16.
REQ-002 The block SHALL have parameter PC_W, default 32: width of saved and restored PCs.
REQ-003 The block SHALL have parameter QNT_W, default 8: width of the time-quantum counter.
REQ-004 The block SHALL have parameter OFS_W, default 12, and OFS_STRIDE, default 1024: width and per-slot step of the RAM offset.
REQ-005 The block SHALL have these ports (ID_W = clog2(NUM_PROC)):
- CLK  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- step  in  1  one instruction retired this cycle.
- next_pc  in  PC_W  PC of the following instruction, valid with step.
- proc_exit  in  1  running process executed halt, valid with step.
- quantum  in  QNT_W  steps per time slice; 0 disables preemption.
- load_valid  in  1  write entry PC into a slot.
- load_id  in  ID_W  target slot.
- load_pc  in  PC_W  entry PC.
- pc_load  out  1  PC takes restore_pc this cycle.
- restore_pc  out  PC_W  PC of the process being dispatched.
- stall  out  1  processor must not advance.
- cur_proc  out  ID_W  running slot.
- proc_offset  out  OFS_W  cur_proc*OFS_STRIDE, truncated to OFS_W.
- in_program  out  1  a process is running.
- active_mask  out  NUM_PROC  slot-valid bits.
- load_err  out  1  one-cycle pulse, load rejected.

Function
REQ-006 The FSM SHALL have four states: IDLE, RUN, SAVE, RESTORE.
REQ-007 stall SHALL equal 1 in every state except RUN; in_program SHALL equal 1 only in RUN.
REQ-008 IDLE SHALL go to SAVE's selection path directly: if active_mask != 0, the next state is RESTORE with the next slot chosen; otherwise it stays in IDLE.
REQ-009 Selection SHALL pick the first valid slot scanning cur_proc+1, cur_proc+2, ... with wrap modulo NUM_PROC; cur_proc itself is the last candidate.
REQ-010 In RUN, a step with quantum != 0 SHALL decrement the slice counter.
REQ-011 In RUN, step with proc_exit=1 or (quantum != 0 and counter == 1) SHALL transition to SAVE on the next edge.
REQ-012 SAVE SHALL write next_pc (captured at the triggering step) into the slot table for cur_proc, or clear active_mask[cur_proc] if proc_exit; it SHALL then run selection on the updated mask, going to RESTORE if a slot is found, else IDLE.
REQ-013 RESTORE SHALL assert pc_load for exactly one cycle with restore_pc = table[selected], update cur_proc and proc_offset, load the counter with quantum, and go to RUN.
REQ-014 Latency SHALL be fixed: triggering step at edge t, SAVE in cycle t+1, pc_load in cycle t+2, first step accepted in cycle t+3.
REQ-015 A sole valid process whose slice expires SHALL be saved and re-dispatched to itself through the same path.
REQ-016 A step arriving outside RUN SHALL be ignored.
REQ-017 load_valid SHALL be accepted in every state and take effect on the next edge, setting active_mask[load_id] and table[load_id]=load_pc.
REQ-018 A load targeting cur_proc while the state is RUN, SAVE, or RESTORE SHALL be dropped and SHALL pulse load_err.
REQ-019 A load arriving in the same cycle as SAVE SHALL NOT be visible to that SAVE's selection.
REQ-020 A change to quantum in RUN SHALL affect only the next slice.

Reset
REQ-021 Asynchronous reset SHALL force the following values: state IDLE, active_mask 0, cur_proc NUM_PROC-1 (so slot 0 dispatches first), counter 0, all outputs 0 except stall=1, and proc_offset = (NUM_PROC-1)*OFS_STRIDE.
REQ-022 Table contents need not be reset.
REQ-023 Reset asserted mid-switch SHALL abandon the switch, with no pc_load after release until a load occurs.

Structure
REQ-024 Package ctx_pkg SHALL hold the state enum and the default parameter constants.
REQ-025 Selection SHALL be a sub-module, rr_next_sel (mask, start id -> found, id), combinational.
REQ-026 The slot table SHALL be a NUM_PROC x PC_W register array.

Verification
REQ-027 Reset, then load slot0=0x100 and slot2=0x200, quantum=3 -> pc_load with restore_pc 0x100, cur_proc 0, proc_offset 0.
REQ-028 Continuing REQ-027: 3 steps with next_pc 0x104,0x108,0x10C -> SAVE; pc_load restore_pc 0x200, cur_proc 2, proc_offset 2048; after 3 more steps, restore_pc 0x10C.
REQ-029 proc_exit on slot 2 -> active_mask 0b0001; slot 0 re-dispatched; a later exit of slot 0 -> IDLE, in_program 0, stall 1.
REQ-030 quantum=0, 1000 steps -> no SAVE entered; load to cur_proc -> load_err pulse, mask unchanged.
REQ-031 NUM_PROC=8, only slot 7 valid, cur_proc=7, expiry -> wraps and re-dispatches slot 7; reset asserted in SAVE -> IDLE and no pc_load.
